mem_access_controller: RTL and testbench

- Sequences data-memory loads and stores issued by the Memory stage of the 5-stage pipeline against a variable-latency data memory with a req/gnt/rvalid handshake.
- Freezes the Fetch, Decode, Execute and Memory stages while an access is outstanding.
- Forces a bubble into the Memory-to-Writeback pipeline register on every stalled cycle.
- Supplies the captured load data as that register's read-data input.
- Bounds every access with a timeout counter.

---
 rtl/mem_access_controller.sv | 139 +++++++++++++
 tb/tb_mem_access_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Load/store sequencer between the Memory stage and a req/gnt/rvalid data memory.
// Stalls F/D/E/M and bubbles M->W while an access is outstanding; every access is time-bounded.
//
// state | meaning
// IDLE  | no access outstanding; a new access in M is latched here
// REQ   | mem_req_o high, waiting for mem_gnt_i
// WAIT  | load granted, waiting for mem_rvalid_i
// RESP  | access done (or timed out); instruction advances to Writeback
module mem_access_controller #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_m_i,
   input  logic                  mem_write_m_i,
   input  logic [DATA_WIDTH-1:0] alu_result_m_i,
   input  logic [DATA_WIDTH-1:0] write_data_m_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  stall_o,
   output logic                  flush_w_o,
   output logic [DATA_WIDTH-1:0] read_data_m_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic access;
   logic timeout;

   assign access  = mem_read_m_i | mem_write_m_i;
   assign timeout = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // gnt/rvalid deliberately ignored here so stale responses are dropped
            if (access) begin
               addr_d  = alu_result_m_i;
               wdata_d = write_data_m_i;
               we_d    = mem_write_m_i & ~mem_read_m_i;
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            // gnt completes a store; for a load only rvalid completes, so a late gnt still times out
            if (mem_gnt_i && we_q) begin
               state_d = ST_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else if (mem_gnt_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (mem_rvalid_i) begin
               rdata_d = mem_rdata_i;
               state_d = ST_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign stall_o       = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ) ||
                          (state_q == ST_WAIT);
   assign flush_w_o     = stall_o;
   assign mem_req_o     = (state_q == ST_REQ);
   assign mem_we_o      = we_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign read_data_m_o = rdata_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed scenarios plus randomized
// accesses checked against a cycle-count/response model derived from the access rules.
module tb_mem_access_controller;

   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read_m_i, mem_write_m_i;
   logic [DW-1:0] alu_result_m_i, write_data_m_i;
   logic          mem_req_o, mem_we_o;
   logic [DW-1:0] mem_addr_o, mem_wdata_o;
   logic          mem_gnt_i, mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          stall_o, flush_w_o;
   logic [DW-1:0] read_data_m_o;
   logic          err_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] model_rdata;

   always #5 clk = ~clk;

   mem_access_controller #(
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read_m_i  (mem_read_m_i),
      .mem_write_m_i (mem_write_m_i),
      .alu_result_m_i(alu_result_m_i),
      .write_data_m_i(write_data_m_i),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .stall_o       (stall_o),
      .flush_w_o     (flush_w_o),
      .read_data_m_o (read_data_m_o),
      .err_o         (err_o)
   );

   typedef struct {
      int          stall_cnt;
      int          req_cnt;
      int          first_req;
      int          resp_cycle;
      int          flush_bad;
      int          err_extra;
      logic [31:0] req_addr;
      logic [31:0] req_wdata;
      logic        req_we;
      bit          req_stable;
      bit          resp_seen;
      logic [31:0] resp_rdata;
      logic        resp_err;
      logic        resp_flush;
      logic        after_stall;
      logic        after_err;
   } acc_res_t;

   // Plays the pipeline (holds the access in M while stalled) and a memory that grants on
   // the g-th request cycle and returns load data r cycles after the grant.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int g, input int r, input bit rv_with_gnt,
                            input bit post_idle, output acc_res_t res);
      int   req_seen;
      int   since;
      bit   gnt_done;
      logic gnt, rv;
      res.stall_cnt = 0;   res.req_cnt = 0;     res.first_req = -1;  res.resp_cycle = -1;
      res.flush_bad = 0;   res.err_extra = 0;   res.req_addr = '0;   res.req_wdata = '0;
      res.req_we = 1'b0;   res.req_stable = 1;  res.resp_seen = 0;   res.resp_rdata = '0;
      res.resp_err = 1'b0; res.resp_flush = 1'b0;
      res.after_stall = 1'b0; res.after_err = 1'b0;
      req_seen = 0; since = 0; gnt_done = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         mem_read_m_i = rd; mem_write_m_i = wr;
         alu_result_m_i = addr; write_data_m_i = wdata;
         #1;
         gnt = mem_req_o && (req_seen + 1 == g);
         if (gnt_done) since++;
         rv = rd && gnt_done && (since == r);
         mem_gnt_i = gnt;
         if (rv) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
         end else if (rv_with_gnt && gnt) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = ~rdata;
         end else begin
            mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
         end
         #1;
         if (flush_w_o !== stall_o) res.flush_bad++;
         if (mem_req_o === 1'b1) begin
            if (res.req_cnt == 0) begin
               res.first_req = cyc;
               res.req_addr  = mem_addr_o;
               res.req_wdata = mem_wdata_o;
               res.req_we    = mem_we_o;
            end else if (mem_addr_o !== res.req_addr || mem_wdata_o !== res.req_wdata ||
                         mem_we_o !== res.req_we) begin
               res.req_stable = 0;
            end
            res.req_cnt++;
            req_seen++;
         end
         if (gnt) begin
            gnt_done = 1; since = 0;
         end
         if (stall_o === 1'b1) begin
            res.stall_cnt++;
            if (err_o !== 1'b0) res.err_extra++;
         end else if (res.stall_cnt > 0) begin
            res.resp_seen  = 1;
            res.resp_cycle = cyc;
            res.resp_rdata = read_data_m_o;
            res.resp_err   = err_o;
            res.resp_flush = flush_w_o;
            break;
         end else if (err_o !== 1'b0) begin
            res.err_extra++;
         end
      end
      if (post_idle) begin
         @(negedge clk);
         mem_read_m_i = 0; mem_write_m_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
         #2;
         res.after_stall = stall_o;
         res.after_err   = err_o;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_read_m_i = 0; mem_write_m_i = 0; alu_result_m_i = '0; write_data_m_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
      n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we_o); end
      n_tests++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
      n_tests++; if (mem_wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
      n_tests++; if (read_data_m_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", read_data_m_o); end
      n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
      n_tests++; if (stall_o !== 1'b0 || flush_w_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b/%b expected 0/0", stall_o, flush_w_o); end
      rst = 1'b0;
      model_rdata = '0;
   endtask

   task automatic test_zero_wait_load();
      acc_res_t res;
      do_access(1, 0, 32'h0000_0040, 32'h5555_0000, 32'hCAFE_F00D, 1, 1, 0, 1, res);
      model_rdata = 32'hCAFE_F00D;
      n_tests++; if (res.stall_cnt !== 3) begin n_fail++; $display("FAIL zw_load_stall: got %0d expected 3", res.stall_cnt); end
      n_tests++; if (res.req_cnt !== 1) begin n_fail++; $display("FAIL zw_load_req: got %0d expected 1", res.req_cnt); end
      n_tests++; if (res.req_addr !== 32'h40 || res.req_we !== 1'b0) begin n_fail++; $display("FAIL zw_load_addr_we: got %h/%b expected 00000040/0", res.req_addr, res.req_we); end
      n_tests++; if (!res.resp_seen || res.resp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL zw_load_rdata: got %h expected cafef00d", res.resp_rdata); end
      n_tests++; if (res.resp_flush !== 1'b0 || res.resp_err !== 1'b0) begin n_fail++; $display("FAIL zw_load_resp_flags: got flush %b err %b expected 0 0", res.resp_flush, res.resp_err); end
      n_tests++; if (res.flush_bad !== 0) begin n_fail++; $display("FAIL zw_load_flush_eq_stall: got %0d bad cycles expected 0", res.flush_bad); end
   endtask

   task automatic test_reset_mid_wait();
      logic saw_wait_stall;
      @(negedge clk);
      mem_read_m_i = 1; mem_write_m_i = 0; alu_result_m_i = 32'h100; write_data_m_i = '0;
      @(negedge clk);
      #1 mem_gnt_i = mem_req_o;
      @(negedge clk);
      mem_gnt_i = 0;
      #1 saw_wait_stall = stall_o;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_read_m_i = 0;
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_DEAD;
      #1;
      n_tests++; if (saw_wait_stall !== 1'b1) begin n_fail++; $display("FAIL rst_wait_pre_stall: got %b expected 1", saw_wait_stall); end
      n_tests++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_wait_idle: got stall %b req %b expected 0 0", stall_o, mem_req_o); end
      n_tests++; if (read_data_m_o !== '0) begin n_fail++; $display("FAIL rst_wait_rdata_cleared: got %h expected 0", read_data_m_o); end
      @(negedge clk);
      mem_gnt_i = 0; mem_rvalid_i = 0;
      #1;
      n_tests++; if (read_data_m_o !== '0 || stall_o !== 1'b0 || mem_req_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rst_wait_rvalid_ignored: got rdata %h stall %b req %b err %b expected 0 0 0 0", read_data_m_o, stall_o, mem_req_o, err_o); end
      model_rdata = '0;
   endtask

   task automatic test_delayed_store();
      acc_res_t res;
      do_access(0, 1, 32'h0000_0080, 32'h1234_5678, 32'h0, 4, 1, 0, 1, res);
      n_tests++; if (res.stall_cnt !== 5) begin n_fail++; $display("FAIL dstore_stall: got %0d expected 5", res.stall_cnt); end
      n_tests++; if (res.req_cnt !== 4 || !res.req_stable) begin n_fail++; $display("FAIL dstore_req_stable: got %0d cycles stable %0d expected 4 1", res.req_cnt, res.req_stable); end
      n_tests++; if (res.req_addr !== 32'h80 || res.req_wdata !== 32'h1234_5678 || res.req_we !== 1'b1) begin n_fail++; $display("FAIL dstore_fields: got %h %h %b expected 00000080 12345678 1", res.req_addr, res.req_wdata, res.req_we); end
      n_tests++; if (res.resp_cycle !== 5) begin n_fail++; $display("FAIL dstore_resp_cycle: got %0d expected 5", res.resp_cycle); end
      n_tests++; if (res.resp_rdata !== model_rdata || res.resp_err !== 1'b0) begin n_fail++; $display("FAIL dstore_rdata_held: got %h err %b expected %h 0", res.resp_rdata, res.resp_err, model_rdata); end
   endtask

   task automatic test_timeout_coincidence();
      acc_res_t res;
      do_access(1, 0, 32'h0000_0200, 32'h0, 32'hAAAA_5555, 1, TO - 1, 1, 1, res);
      model_rdata = 32'hAAAA_5555;
      n_tests++; if (res.stall_cnt !== TO + 1) begin n_fail++; $display("FAIL tcoin_stall: got %0d expected %0d", res.stall_cnt, TO + 1); end
      n_tests++; if (res.resp_err !== 1'b0 || res.err_extra !== 0 || res.after_err !== 1'b0) begin n_fail++; $display("FAIL tcoin_err: got %b extra %0d after %b expected 0 0 0", res.resp_err, res.err_extra, res.after_err); end
      n_tests++; if (res.resp_rdata !== 32'hAAAA_5555) begin n_fail++; $display("FAIL tcoin_rdata: got %h expected aaaa5555", res.resp_rdata); end
   endtask

   task automatic test_timeout();
      acc_res_t res;
      do_access(1, 0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1, 1000, 0, 1, res);
      model_rdata = '0;
      n_tests++; if (!res.resp_seen || res.stall_cnt !== TO + 1) begin n_fail++; $display("FAIL timeout_stall: got %0d seen %0d expected %0d 1", res.stall_cnt, res.resp_seen, TO + 1); end
      n_tests++; if (res.resp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 1", res.resp_err); end
      n_tests++; if (res.err_extra !== 0 || res.after_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_width: got extra %0d after %b expected 0 0", res.err_extra, res.after_err); end
      n_tests++; if (res.resp_rdata !== '0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", res.resp_rdata); end
      n_tests++; if (res.after_stall !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got stall %b expected 0", res.after_stall); end
   endtask

   task automatic test_back_to_back();
      acc_res_t r1, r2, r3;
      do_access(1, 0, 32'h0000_0400, 32'h0, 32'h1111_2222, 1, 1, 0, 0, r1);
      do_access(0, 1, 32'h0000_0404, 32'h9999_8888, 32'h0, 1, 1, 0, 0, r2);
      do_access(1, 1, 32'h0000_0408, 32'h7777_6666, 32'h3333_4444, 1, 2, 0, 1, r3);
      model_rdata = 32'h3333_4444;
      n_tests++; if (r1.stall_cnt !== 3 || r1.resp_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_load: got stall %0d rdata %h expected 3 11112222", r1.stall_cnt, r1.resp_rdata); end
      n_tests++; if (r2.first_req !== 1 || r2.req_cnt !== 1 || r2.stall_cnt !== 2) begin n_fail++; $display("FAIL b2b_store_issue: got first %0d reqs %0d stall %0d expected 1 1 2", r2.first_req, r2.req_cnt, r2.stall_cnt); end
      n_tests++; if (r2.req_addr !== 32'h404 || r2.req_we !== 1'b1 || r2.resp_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_store_fields: got %h we %b rdata %h expected 00000404 1 11112222", r2.req_addr, r2.req_we, r2.resp_rdata); end
      n_tests++; if (r3.req_we !== 1'b0 || r3.req_cnt !== 1 || r3.stall_cnt !== 4) begin n_fail++; $display("FAIL dual_as_load: got we %b reqs %0d stall %0d expected 0 1 4", r3.req_we, r3.req_cnt, r3.stall_cnt); end
      n_tests++; if (r3.resp_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL dual_rdata: got %h expected 33334444", r3.resp_rdata); end
   endtask

   // Model: an access stalls one detect cycle plus its REQ+WAIT cycles, capped at TO;
   // it times out when the completing event would land beyond the TO-th cycle.
   task automatic test_random();
      acc_res_t    res;
      logic        rd, wr, exp_we, exp_err;
      logic [31:0] addr, wdata, rdata, exp_rdata;
      int          g, r, total, exp_stall, exp_req;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: begin rd = 1; wr = 0; end
            1: begin rd = 0; wr = 1; end
            default: begin rd = 1; wr = 1; end
         endcase
         addr  = $urandom; wdata = $urandom; rdata = $urandom;
         g = $urandom_range(1, 18);
         r = $urandom_range(1, 6);
         total     = rd ? g + r : g;
         exp_err   = (total > TO);
         exp_stall = 1 + (exp_err ? TO : total);
         exp_req   = (g < TO) ? g : TO;
         exp_we    = wr & ~rd;
         exp_rdata = exp_err ? 32'h0 : (rd ? rdata : model_rdata);
         do_access(rd, wr, addr, wdata, rdata, g, r, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), res);
         model_rdata = exp_rdata;
         n_tests++; if (res.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d expected %0d", i, res.stall_cnt, exp_stall); end
         n_tests++; if (res.req_cnt !== exp_req || !res.req_stable) begin n_fail++; $display("FAIL rnd%0d_req: got %0d stable %0d expected %0d 1", i, res.req_cnt, res.req_stable, exp_req); end
         n_tests++; if (res.req_addr !== addr || res.req_wdata !== wdata || res.req_we !== exp_we) begin n_fail++; $display("FAIL rnd%0d_fields: got %h %h %b expected %h %h %b", i, res.req_addr, res.req_wdata, res.req_we, addr, wdata, exp_we); end
         n_tests++; if (res.resp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, res.resp_rdata, exp_rdata); end
         n_tests++; if (res.resp_err !== exp_err || res.err_extra !== 0) begin n_fail++; $display("FAIL rnd%0d_err: got %b extra %0d expected %b 0", i, res.resp_err, res.err_extra, exp_err); end
         n_tests++; if (res.flush_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_flush: got %0d bad cycles expected 0", i, res.flush_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_load();
      test_reset_mid_wait();
      test_delayed_store();
      test_timeout_coincidence();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
